simple_mem_bridge: RTL and testbench
====================================

Name: simple_mem_bridge

Overview:
- Parametrised on-chip RAM controller for the SimpleCore memory bus. It replaces the fixed single-cycle 32-bit-only RAM responder.
- Supports 8/16/32/64-bit accesses with byte-lane merging, a configurable base address and depth, programmable wait states, and one-shot ready/busx handshaking.
- Sits between SimpleCore and block RAM in MCU-level top modules.

Parameters:
- DEPTH_LOG2, 13: log2 of the RAM depth in 32-bit words.
- BASE_ADDR, 64'h0: byte address of RAM word 0.
- WAIT_STATES, 0: extra cycles inserted before each RAM access. Range 0..15.
- ROM_WORDS, 16: number of words from word 0 that are write-protected. Used only with SIMPLE_MEM_ROM_EN.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- address, input, 64: byte address from the core.
- dsize, input, 2: access size. 0=8, 1=16, 2=32, 3=64 bits.
- readins, input, 1: instruction-fetch request (level).
- readmem, input, 1: data-read request (level).
- writemem, input, 1: data-write request (level).
- dout, input, 64: write data from the core. Valid bits are right-aligned.
- din, output, 64: read data to the core. Zero-extended, right-aligned.
- ready, output, 1: one-cycle pulse marking successful completion.
- busx, output, 1: one-cycle pulse marking a bus exception.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ready=0; busx=0; din=0; wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACC_LO, ACC_HI, RESP, DRAIN.
- IDLE: the request is sampled when any strobe is 1. The bridge latches address, dsize, dout and request type. Exception checks are evaluated in the same cycle.
- Exception conditions:
  - more than one strobe high;
  - readins with dsize!=2;
  - address[dsize-1:0]!=0 (misaligned);
  - offset=address-BASE_ADDR outside [0, 4<<DEPTH_LOG2), including the last byte (offset+size-1). The 64-bit subtraction wraps; an address below the base therefore fails the check.
- On exception: busx=1 for exactly one cycle, then DRAIN. No RAM write occurs and din is unchanged.
- On a valid request: go to WAIT if WAIT_STATES>0, else ACC_LO. WAIT counts WAIT_STATES cycles, then goes to ACC_LO.
- ACC_LO: accesses word offset[DEPTH_LOG2+1:2].
  - Reads: select the byte lanes (little-endian, lane=offset[1:0]) and zero-extend.
  - Writes: merge only the addressed lanes (byte enables). Unaddressed bytes are preserved.
  - dsize=3 goes to ACC_HI; all other sizes go to RESP.
- ACC_HI: accesses word+1. A read places that word in din[63:32]; a write stores dout[63:32].
- RESP: ready=1 for exactly one cycle. For reads, din is updated in the same cycle ready rises. din holds its value until the next read response.
- DRAIN: waits until all strobes are 0, then returns to IDLE. This guarantees one access per request.
- Latency, for a request first seen in IDLE at cycle T:
  - ready at T+2+WAIT_STATES for sizes 8/16/32;
  - ready at T+3+WAIT_STATES for 64-bit;
  - busx at T+1.
- Minimum turnaround is one idle-strobe cycle between requests.
- Strobe changes after sampling are ignored until DRAIN.
- Reset mid-operation aborts immediately. If the reset lands between ACC_LO and ACC_HI of a 64-bit write, the low word is committed and the high word is not.
- A RAM write and a RAM read never occur in the same cycle.

Optional Feature:
- Macro: SIMPLE_MEM_ROM_EN.
- Defined: any writemem touching word index <ROM_WORDS, on either half of a 64-bit access, is an exception. busx is pulsed, nothing is written, and the request is classified in IDLE with no wait states. Reads from these words are unaffected.
- Undefined: the whole array is writable and ROM_WORDS is ignored.

Test Plan:
- 32-bit write then read at address 0x40 with dout=0x0000_0000_DEADBEEF (WAIT_STATES=0): ready at T+2 each time; read returns din=0x00000000DEADBEEF.
- Byte write 0xAA to 0x41 over word 0x11223344, then 32-bit read: din=0x1122AA44. A 16-bit read at 0x42 returns 0x1122.
- 64-bit write to 0x80 with dout=0x0123456789ABCDEF, WAIT_STATES=3, then 64-bit read: ready at T+6; words 0x20=0x89ABCDEF and 0x21=0x01234567; read returns the full value.
- Misaligned 32-bit read at 0x42, readins with dsize=1, and a read at BASE_ADDR+(4<<DEPTH_LOG2) all give busx at T+1, ready=0, and din unchanged.
- Strobe held high for 10 cycles on a write: exactly one ready pulse and one RAM write; the next request is accepted only after the strobe drops.
- With SIMPLE_MEM_ROM_EN and ROM_WORDS=16, a write to 0x3C gives busx and the RAM is unchanged, while a write to 0x40 gives ready. Asserting reset low during WAIT clears ready/busx asynchronously and leaves the RAM untouched.

Source files
------------

// File: rtl/simple_mem_bridge.sv
// SimpleCore on-chip RAM bridge: 8/16/32/64-bit accesses, wait states, busx on bad requests.
// Define SIMPLE_MEM_ROM_EN to write-protect the first ROM_WORDS words.
module simple_mem_bridge #(
    parameter int          DEPTH_LOG2  = 13,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WAIT_STATES = 0,
    parameter int          ROM_WORDS   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic [1:0]  dsize,
    input  logic        readins,
    input  logic        readmem,
    input  logic        writemem,
    input  logic [63:0] dout,
    output logic [63:0] din,
    output logic        ready,
    output logic        busx
);

    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [63:0] LIMIT = 64'(4) << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACC_LO, S_ACC_HI, S_RESP, S_DRAIN
    } state_t;

    state_t state, nstate;

    logic [31:0] mem [WORDS];

    logic                  any_req, multi, bad_ins, misalign, in_range;
    logic                  rom_hit, exc;
    logic [63:0]           offset;
    logic [3:0]            nbytes;
    logic [2:0]            amask;

    logic [DEPTH_LOG2-1:0] q_word;
    logic [1:0]            q_lane;
    logic [1:0]            q_size;
    logic [63:0]           q_wdata;
    logic                  q_write;
    logic [3:0]            cnt;
    logic [31:0]           lo_q;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wd;
    logic [31:0]           rword, rshift, rsel;
    logic [3:0]            lane_mask;

    assign any_req = readins | readmem | writemem;
    assign multi   = (readins & readmem) | (readins & writemem)
                   | (readmem & writemem);
    assign bad_ins = readins && (dsize != 2'd2);
    assign offset  = address - BASE_ADDR;

    always_comb begin
        nbytes = 4'd1;
        amask  = 3'd0;
        unique case (dsize)
            2'd0: begin nbytes = 4'd1; amask = 3'd0; end
            2'd1: begin nbytes = 4'd2; amask = 3'd1; end
            2'd2: begin nbytes = 4'd4; amask = 3'd3; end
            2'd3: begin nbytes = 4'd8; amask = 3'd7; end
        endcase
    end

    // offset < LIMIT keeps the end-of-access sum from overflowing
    assign misalign = |(address[2:0] & amask);
    assign in_range = (offset < LIMIT)
                   && ((offset + 64'(nbytes)) <= LIMIT);

`ifdef SIMPLE_MEM_ROM_EN
    assign rom_hit = writemem && (offset[63:2] < 62'(ROM_WORDS));
`else
    assign rom_hit = 1'b0 & (ROM_WORDS != 0);
`endif

    assign exc = multi | bad_ins | misalign | ~in_range | rom_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (exc)                  nstate = S_DRAIN;
                    else if (WAIT_STATES > 0) nstate = S_WAIT;
                    else                      nstate = S_ACC_LO;
                end
            end
            S_WAIT: begin
                if (cnt == 4'(WAIT_STATES - 1)) nstate = S_ACC_LO;
            end
            S_ACC_LO: nstate = (q_size == 2'd3) ? S_ACC_HI : S_RESP;
            S_ACC_HI: nstate = S_RESP;
            S_RESP:   nstate = S_DRAIN;
            S_DRAIN:  if (!any_req) nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == S_RESP);
        mem_we    = q_write && (state == S_ACC_LO || state == S_ACC_HI);
        lane_mask = 4'b1111;
        unique case (q_size)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        if (state == S_ACC_HI) begin
            mem_idx = q_word + DEPTH_LOG2'(1);
            mem_be  = 4'b1111;
            mem_wd  = q_wdata[63:32];
        end else begin
            mem_idx = q_word;
            mem_be  = lane_mask << q_lane;
            mem_wd  = q_wdata[31:0] << {q_lane, 3'b000};
        end
    end

    assign rword  = mem[mem_idx];
    assign rshift = rword >> {q_lane, 3'b000};

    always_comb begin
        rsel = rshift;
        unique case (q_size)
            2'd0:    rsel = {24'd0, rshift[7:0]};
            2'd1:    rsel = {16'd0, rshift[15:0]};
            default: rsel = rshift;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            din     <= '0;
            busx    <= 1'b0;
            cnt     <= '0;
            q_word  <= '0;
            q_lane  <= '0;
            q_size  <= '0;
            q_wdata <= '0;
            q_write <= 1'b0;
            lo_q    <= '0;
        end else begin
            busx <= (state == S_IDLE) && any_req && exc;
            if (state == S_IDLE && any_req) begin
                q_word  <= offset[DEPTH_LOG2+1:2];
                q_lane  <= offset[1:0];
                q_size  <= dsize;
                q_wdata <= dout;
                q_write <= writemem;
                cnt     <= '0;
            end
            if (state == S_WAIT) cnt <= cnt + 4'd1;
            if (state == S_ACC_LO && !q_write) begin
                if (q_size == 2'd3) lo_q <= rword;
                else                din  <= {32'd0, rsel};
            end
            if (state == S_ACC_HI && !q_write) din <= {rword, lo_q};
        end
    end

    // Array is left unreset so contents survive a bridge reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_simple_mem_bridge.sv
// Directed bench for simple_mem_bridge: one zero-wait instance, one
// three-wait instance with a non-zero base.
module tb_simple_mem_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [63:0] a_addr = '0, a_dout = '0, a_din;
    logic [1:0]  a_dsize = '0;
    logic        a_ri = 0, a_rm = 0, a_wm = 0, a_ready, a_busx;

    logic [63:0] b_addr = '0, b_dout = '0, b_din;
    logic [1:0]  b_dsize = '0;
    logic        b_ri = 0, b_rm = 0, b_wm = 0, b_ready, b_busx;

    int          tests = 0;
    int          fails = 0;

    int          lat, pulses;
    logic        gb, gr;
    logic [63:0] dv, v0, rom_exp;
    int          rom_lat;

    always #5 clock = ~clock;

    simple_mem_bridge #(
        .DEPTH_LOG2(13), .BASE_ADDR(64'h0), .WAIT_STATES(0), .ROM_WORDS(16)
    ) u_a (
        .clock(clock), .reset(reset), .address(a_addr), .dsize(a_dsize),
        .readins(a_ri), .readmem(a_rm), .writemem(a_wm), .dout(a_dout),
        .din(a_din), .ready(a_ready), .busx(a_busx)
    );

    simple_mem_bridge #(
        .DEPTH_LOG2(6), .BASE_ADDR(64'h1000), .WAIT_STATES(3), .ROM_WORDS(16)
    ) u_b (
        .clock(clock), .reset(reset), .address(b_addr), .dsize(b_dsize),
        .readins(b_ri), .readmem(b_rm), .writemem(b_wm), .dout(b_dout),
        .din(b_din), .ready(b_ready), .busx(b_busx)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [2:0] strb,
                         input logic [63:0] addr, input logic [1:0] sz,
                         input logic [63:0] wd);
        if (sel) begin
            {b_ri, b_rm, b_wm} = strb;
            b_addr = addr; b_dsize = sz; b_dout = wd;
        end else begin
            {a_ri, a_rm, a_wm} = strb;
            a_addr = addr; a_dsize = sz; a_dout = wd;
        end
    endtask

    // strb = {readins, readmem, writemem}; strobes stay up at least hold cycles
    task automatic run(input bit sel, input logic [2:0] strb,
                       input logic [63:0] addr, input logic [1:0] sz,
                       input logic [63:0] wd, input int hold);
        logic r, x;
        bit   up;
        @(posedge clock); #1;
        drive(sel, strb, addr, sz, wd);
        up = 1'b1;
        lat = -1; pulses = 0; gb = 0; gr = 0; dv = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            r = sel ? b_ready : a_ready;
            x = sel ? b_busx  : a_busx;
            if (r || x) begin
                pulses++;
                if (lat < 0) begin
                    lat = n; gb = x; gr = r;
                    dv  = sel ? b_din : a_din;
                end
            end
            if (up && lat >= 0 && n >= hold) begin
                drive(sel, 3'b000, '0, 2'd0, '0);
                up = 1'b0;
            end
        end
        drive(sel, 3'b000, '0, 2'd0, '0);
    endtask

    initial begin
        #1;
        chk("rst_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_busx", {63'd0, a_busx}, 64'd0);
        chk("rst_din_a", a_din, 64'd0);
        chk("rst_din_b", b_din, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        run(0, 3'b001, 64'h40, 2'd2, 64'h0000_0000_DEAD_BEEF, 0);
        chk("w32_lat", 64'(lat), 64'd2);
        chk("w32_busx", {63'd0, gb}, 64'd0);
        run(0, 3'b010, 64'h40, 2'd2, '0, 0);
        chk("r32_lat", 64'(lat), 64'd2);
        chk("r32_din", dv, 64'h0000_0000_DEAD_BEEF);

        run(0, 3'b001, 64'h40, 2'd2, 64'h1122_3344, 0);
        run(0, 3'b001, 64'h41, 2'd0, 64'hFFFF_FFFF_FFFF_FFAA, 0);
        chk("w8_lat", 64'(lat), 64'd2);
        run(0, 3'b010, 64'h40, 2'd2, '0, 0);
        chk("merge_din", dv, 64'h1122_AA44);
        run(0, 3'b010, 64'h42, 2'd1, '0, 0);
        chk("r16_din", dv, 64'h1122);
        run(0, 3'b010, 64'h43, 2'd0, '0, 0);
        chk("r8_din", dv, 64'h11);
        run(0, 3'b100, 64'h40, 2'd2, '0, 0);
        chk("ins_lat", 64'(lat), 64'd2);
        chk("ins_din", dv, 64'h1122_AA44);

        run(0, 3'b010, 64'h42, 2'd2, '0, 0);
        chk("mis_lat", 64'(lat), 64'd1);
        chk("mis_busx", {63'd0, gb}, 64'd1);
        chk("mis_ready", {63'd0, gr}, 64'd0);
        chk("mis_pulses", 64'(pulses), 64'd1);
        chk("mis_din", a_din, 64'h1122_AA44);
        run(0, 3'b100, 64'h40, 2'd1, '0, 0);
        chk("ins16_busx", {63'd0, gb}, 64'd1);
        chk("ins16_lat", 64'(lat), 64'd1);
        run(0, 3'b010, 64'h8000, 2'd2, '0, 0);
        chk("oor_busx", {63'd0, gb}, 64'd1);
        chk("oor_din", a_din, 64'h1122_AA44);
        run(0, 3'b010, 64'h7FFF, 2'd0, '0, 0);
        chk("last_byte_lat", 64'(lat), 64'd2);
        chk("last_byte_busx", {63'd0, gb}, 64'd0);
        run(0, 3'b011, 64'h40, 2'd2, '0, 0);
        chk("multi_busx", {63'd0, gb}, 64'd1);
        run(0, 3'b001, 64'h7FFC, 2'd3, 64'h1, 0);
        chk("mis64_busx", {63'd0, gb}, 64'd1);

        run(0, 3'b001, 64'h7FF8, 2'd3, 64'hA5A5_0F0F_5A5A_F0F0, 0);
        chk("w64top_lat", 64'(lat), 64'd3);
        run(0, 3'b010, 64'h7FF8, 2'd3, '0, 0);
        chk("r64top_din", dv, 64'hA5A5_0F0F_5A5A_F0F0);

        run(0, 3'b001, 64'h44, 2'd2, 64'h5566_7788, 10);
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_lat", 64'(lat), 64'd2);
        run(0, 3'b010, 64'h44, 2'd2, '0, 0);
        chk("hold_next_lat", 64'(lat), 64'd2);
        chk("hold_din", dv, 64'h5566_7788);

        run(0, 3'b010, 64'h3C, 2'd2, '0, 0);
        v0 = dv;
`ifdef SIMPLE_MEM_ROM_EN
        rom_exp = v0;
        rom_lat = 1;
`else
        rom_exp = 64'h0BAD_F00D;
        rom_lat = 2;
`endif
        run(0, 3'b001, 64'h3C, 2'd2, 64'h0BAD_F00D, 0);
        chk("rom_w_lat", 64'(lat), 64'(rom_lat));
        run(0, 3'b010, 64'h3C, 2'd2, '0, 0);
        chk("rom_r_din", dv, rom_exp);
        run(0, 3'b001, 64'h40, 2'd2, 64'h7777_8888, 0);
        chk("rom_edge_ready", {63'd0, gr}, 64'd1);

        run(1, 3'b001, 64'h1080, 2'd3, 64'h0123_4567_89AB_CDEF, 0);
        chk("b_w64_lat", 64'(lat), 64'd6);
        run(1, 3'b010, 64'h1080, 2'd2, '0, 0);
        chk("b_r32_lat", 64'(lat), 64'd5);
        chk("b_word20", dv, 64'h89AB_CDEF);
        run(1, 3'b010, 64'h1084, 2'd2, '0, 0);
        chk("b_word21", dv, 64'h0123_4567);
        run(1, 3'b010, 64'h1080, 2'd3, '0, 0);
        chk("b_r64_lat", 64'(lat), 64'd6);
        chk("b_r64_din", dv, 64'h0123_4567_89AB_CDEF);
        run(1, 3'b010, 64'h0FFC, 2'd2, '0, 0);
        chk("b_below_busx", {63'd0, gb}, 64'd1);
        chk("b_below_lat", 64'(lat), 64'd1);
        run(1, 3'b010, 64'h1100, 2'd2, '0, 0);
        chk("b_top_busx", {63'd0, gb}, 64'd1);
        run(1, 3'b010, 64'h1086, 2'd1, '0, 0);
        chk("b_r16_din", dv, 64'h0123);

        @(posedge clock); #1;
        drive(1, 3'b010, 64'h1100, 2'd2, '0);
        @(posedge clock); #1;
        chk("b_rst_busx_pre", {63'd0, b_busx}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("b_rst_busx", {63'd0, b_busx}, 64'd0);
        chk("b_rst_din", b_din, 64'd0);
        drive(1, 3'b000, '0, 2'd0, '0);
        @(posedge clock); #1 reset = 1'b1;

        @(posedge clock); #1;
        drive(1, 3'b001, 64'h1080, 2'd2, 64'hCAFE_F00D);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("b_wait_rst_ready", {63'd0, b_ready}, 64'd0);
        chk("b_wait_rst_busx", {63'd0, b_busx}, 64'd0);
        drive(1, 3'b000, '0, 2'd0, '0);
        @(posedge clock); #1 reset = 1'b1;
        run(1, 3'b010, 64'h1080, 2'd2, '0, 0);
        chk("b_wait_rst_mem", dv, 64'h89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
